// File: rtl/mem_request_responder.sv
// Memory-side responder for the datapath cache request interface.
// Arbitrates data and instruction requests onto one variable-latency RAM
// port (data first), returns single-cycle ihit/dhit pulses with load data,
// and counts completed accesses. A RAM error or a stalled access parks the
// block in a sticky error state that only RST clears.
module mem_request_responder #(
    parameter int TIMEOUT = 255,  // RAM wait cycles allowed per access
    parameter int TW      = 8,    // timeout counter width, TIMEOUT < 2**TW
    parameter int CW      = 32    // access counter width
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          imemREN,
    input  logic [31:0]   imemaddr,
    input  logic          dmemREN,
    input  logic          dmemWEN,
    input  logic [31:0]   dmemaddr,
    input  logic [31:0]   dmemstore,
    output logic          ihit,
    output logic [31:0]   imemload,
    output logic          dhit,
    output logic [31:0]   dmemload,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [31:0]   ramaddr,
    output logic [31:0]   ramstore,
    input  logic [31:0]   ramload,
    input  logic [1:0]    ramstate,
    output logic          memerr,
    output logic [CW-1:0] iacc_cnt,
    output logic [CW-1:0] dacc_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DACC,
        S_IACC,
        S_DRSP,
        S_IRSP,
        S_ERR
    } state_t;

    localparam logic [1:0]    RAM_ACCESS = 2'd2;
    localparam logic [1:0]    RAM_ERROR  = 2'd3;
    // The counter starts at 0 on the first access cycle, so TIMEOUT-1 marks
    // the last allowed wait cycle.
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    state_t          r_state;
    logic [31:0]     r_iaddr;     // latched fetch address, compared in IRSP
    logic            r_dwen;      // latched data op: 1 = write
    logic [TW-1:0]   r_tmo;
    logic            r_dhit;
    logic [31:0]     r_imemload;
    logic [31:0]     r_dmemload;
    logic            r_ramREN;
    logic            r_ramWEN;
    logic [31:0]     r_ramaddr;
    logic [31:0]     r_ramstore;
    logic            r_memerr;
    logic [CW-1:0]   r_iacc_cnt;
    logic [CW-1:0]   r_dacc_cnt;

    logic w_data_req;
    logic w_ihit;
    logic w_acc_done;
    logic w_acc_fail;

    assign w_data_req = dmemREN | dmemWEN;
    assign w_acc_done = (ramstate == RAM_ACCESS);
    assign w_acc_fail = (ramstate == RAM_ERROR) || (r_tmo == TMO_LAST);
    // The fetch response is only delivered if the pipeline still wants the
    // same address during IRSP; a flush or redirect drops it silently, so
    // ihit is qualified by the live request lines in that cycle.
    assign w_ihit     = (r_state == S_IRSP) && imemREN && (imemaddr == r_iaddr);

    // Request arbitration, RAM access sequencing, responses and statistics.
    always_ff @(posedge CLK) begin
        // NOTE: every register, including load data and counters, clears on
        // reset and all state updates are non-blocking so each branch reads
        // the pre-edge values of r_state, r_tmo and the latched request.
        if (RST) begin
            r_state    <= S_IDLE;
            r_iaddr    <= '0;
            r_dwen     <= 1'b0;
            r_tmo      <= '0;
            r_dhit     <= 1'b0;
            r_imemload <= '0;
            r_dmemload <= '0;
            r_ramREN   <= 1'b0;
            r_ramWEN   <= 1'b0;
            r_ramaddr  <= '0;
            r_ramstore <= '0;
            r_memerr   <= 1'b0;
            r_iacc_cnt <= '0;
            r_dacc_cnt <= '0;
        end else begin
            r_dhit <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tmo <= '0;
                    if (w_data_req) begin
                        // Write wins when both data strobes are raised.
                        r_dwen     <= dmemWEN;
                        r_ramREN   <= ~dmemWEN;
                        r_ramWEN   <= dmemWEN;
                        r_ramaddr  <= dmemaddr;
                        r_ramstore <= dmemstore;
                        r_state    <= S_DACC;
                    end else if (imemREN) begin
                        r_iaddr    <= imemaddr;
                        r_ramREN   <= 1'b1;
                        r_ramWEN   <= 1'b0;
                        r_ramaddr  <= imemaddr;
                        r_ramstore <= '0;
                        r_state    <= S_IACC;
                    end
                end
                S_DACC, S_IACC: begin
                    if (w_acc_done || w_acc_fail) begin
                        r_ramREN   <= 1'b0;
                        r_ramWEN   <= 1'b0;
                        r_ramaddr  <= '0;
                        r_ramstore <= '0;
                        r_tmo      <= '0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                    // A completed access takes precedence over a timeout
                    // landing in the same cycle.
                    if (w_acc_done) begin
                        if (r_state == S_DACC) begin
                            r_dmemload <= r_dwen ? 32'd0 : ramload;
                            r_dhit     <= 1'b1;
                            r_state    <= S_DRSP;
                        end else begin
                            r_imemload <= ramload;
                            r_state    <= S_IRSP;
                        end
                    end else if (w_acc_fail) begin
                        r_memerr <= 1'b1;
                        r_state  <= S_ERR;
                    end
                end
                S_DRSP: begin
                    r_dacc_cnt <= r_dacc_cnt + CW'(1);
                    r_state    <= S_IDLE;
                end
                S_IRSP: begin
                    if (w_ihit) begin
                        r_iacc_cnt <= r_iacc_cnt + CW'(1);
                    end
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_memerr <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ihit     = w_ihit;
    assign imemload = r_imemload;
    assign dhit     = r_dhit;
    assign dmemload = r_dmemload;
    assign ramREN   = r_ramREN;
    assign ramWEN   = r_ramWEN;
    assign ramaddr  = r_ramaddr;
    assign ramstore = r_ramstore;
    assign memerr   = r_memerr;
    assign iacc_cnt = r_iacc_cnt;
    assign dacc_cnt = r_dacc_cnt;

endmodule

// File: tb/tb_mem_request_responder.sv
// Self-checking bench for mem_request_responder: reset values, a table of
// single transactions, directed multi-cycle corner cases, and randomized
// transactions scored against a transaction-level reference model.
module tb_mem_request_responder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN, dmemREN, dmemWEN;
    logic [31:0] imemaddr, dmemaddr, dmemstore;
    logic        ihit, dhit;
    logic [31:0] imemload, dmemload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    logic        memerr;
    logic [31:0] iacc_cnt, dacc_cnt;

    mem_request_responder dut (
        .CLK(CLK), .RST(RST),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .memerr(memerr), .iacc_cnt(iacc_cnt), .dacc_cnt(dacc_cnt)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    // RAM model state (stimulus side)
    bit ram_auto = 1'b1;
    int ram_lat  = 0;
    int busy_left = 0;
    bit in_acc = 1'b0;
    logic [31:0] ram_mem [logic [31:0]];
    // Reference model state (expectation side)
    logic [31:0] ref_mem [logic [31:0]];
    int ref_i = 0;
    int ref_d = 0;

    typedef struct {
        bit          ireq;
        bit          dren;
        bit          dwen;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] dstore;
        int          lat;
        bit          preset;
        logic [31:0] pdata;
        int          ekind;   // 0 = ihit, 1 = dhit
        int          ecyc;    // cycle of the hit, request cycle = 1
        logic [31:0] eload;
    } vec_t;

    typedef struct {
        int          kind;
        int          at;
        logic [31:0] ld;
    } ev_t;

    vec_t vecs[8];
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    function automatic logic [31:0] ram_init(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return ram_init(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return ram_init(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock, then let the RAM model answer the strobes now visible.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (ram_auto) begin
            if (ramREN || ramWEN) begin
                if (!in_acc) begin
                    in_acc    = 1'b1;
                    busy_left = ram_lat;
                end
                if (busy_left > 0) begin
                    ramstate = 2'd1;
                    busy_left--;
                    ramload = $urandom;
                end else begin
                    ramstate = 2'd2;
                    if (ramWEN) begin
                        ram_mem[ramaddr] = ramstore;
                        ramload = $urandom;
                    end else begin
                        ramload = ram_rd(ramaddr);
                    end
                    in_acc = 1'b0;
                end
            end else begin
                ramstate = 2'd0;
                in_acc   = 1'b0;
                ramload  = $urandom;
            end
        end
        check("hit_exclusive", 64'(ihit & dhit), 64'd0);
    endtask

    task automatic clear_reqs();
        imemREN = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        clear_reqs();
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic run_until_hit(input int budget, output int kind, output int at,
                                 output logic [31:0] ld);
        kind = -1;
        at   = 0;
        ld   = '0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (dhit) begin
                kind = 1; at = cyc; ld = dmemload;
                return;
            end
            if (ihit) begin
                kind = 0; at = cyc; ld = imemload;
                return;
            end
        end
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        int          kind, at, nstb;
        logic [31:0] ld, acc_addr, i0, d0;
        bit          data, wen;
        data     = v.dren | v.dwen;
        wen      = v.dwen;
        acc_addr = data ? v.daddr : v.iaddr;
        ram_auto = 1'b1;
        ram_lat  = v.lat;
        if (v.preset) ram_mem[acc_addr] = v.pdata;
        i0 = iacc_cnt;
        d0 = dacc_cnt;
        imemREN = v.ireq; imemaddr = v.iaddr;
        dmemREN = v.dren; dmemWEN = v.dwen;
        dmemaddr = v.daddr; dmemstore = v.dstore;
        cyc  = 1;
        kind = -1; at = 0; ld = '0; nstb = 0;
        for (int k = 0; k < 30 && kind < 0; k++) begin
            tick();
            if (ramREN || ramWEN) begin
                nstb++;
                check($sformatf("vec%0d_strobes", idx),
                      {ramREN, ramWEN, ramaddr, (wen ? ramstore : 32'd0)},
                      {!wen, wen, acc_addr, (wen ? v.dstore : 32'd0)});
            end
            if (dhit) begin kind = 1; at = cyc; ld = dmemload; end
            else if (ihit) begin kind = 0; at = cyc; ld = imemload; end
        end
        tick();
        clear_reqs();
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("vec%0d_no_extra_hit", idx), 64'(ihit | dhit), 64'd0);
        end
        check($sformatf("vec%0d_kind", idx), 64'(kind), 64'(v.ekind));
        check($sformatf("vec%0d_cycle", idx), 64'(at), 64'(v.ecyc));
        check($sformatf("vec%0d_load", idx), 64'(ld), 64'(v.eload));
        check($sformatf("vec%0d_acc_cycles", idx), 64'(nstb), 64'(v.lat + 1));
        check($sformatf("vec%0d_iacc", idx), 64'(iacc_cnt), 64'(i0 + 32'(v.ekind == 0)));
        check($sformatf("vec%0d_dacc", idx), 64'(dacc_cnt), 64'(d0 + 32'(v.ekind == 1)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, expected to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          kind, at;
        logic [31:0] ld, i0;
        bit          seen;

        //            ireq dren dwen iaddr       daddr       dstore        lat pre pdata         kind cyc eload
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0,   32'h0,        0, 1'b1, 32'h8C220004, 0, 3, 32'h8C220004};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h100, 32'h0,        0, 1'b1, 32'hDEADBEEF, 1, 3, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'h200, 32'h12345678, 4, 1'b0, 32'h0,        1, 7, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h200, 32'h0,        2, 1'b0, 32'h0,        1, 5, 32'h12345678};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h300, 32'hCAFEF00D, 1, 1'b0, 32'h0,        1, 4, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h300, 32'h0,        0, 1'b0, 32'h0,        1, 3, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h80, 32'h0,   32'h0,        3, 1'b1, 32'h01234567, 0, 6, 32'h01234567};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h44, 32'h44,  32'h0BADF00D, 0, 1'b0, 32'h0,        1, 3, 32'h0};

        clear_reqs();
        imemaddr = '0; dmemaddr = '0; dmemstore = '0;
        ramstate = 2'd0; ramload = '0;
        do_reset();

        // Reset state
        check("rst_ihit", 64'(ihit), 64'd0);
        check("rst_dhit", 64'(dhit), 64'd0);
        check("rst_imemload", 64'(imemload), 64'd0);
        check("rst_dmemload", 64'(dmemload), 64'd0);
        check("rst_ram_strobes", 64'({ramREN, ramWEN}), 64'd0);
        check("rst_ramaddr", 64'(ramaddr), 64'd0);
        check("rst_ramstore", 64'(ramstore), 64'd0);
        check("rst_memerr", 64'(memerr), 64'd0);
        check("rst_iacc", 64'(iacc_cnt), 64'd0);
        check("rst_dacc", 64'(dacc_cnt), 64'd0);

        // Single transactions from the table
        for (int i = 0; i < 8; i++) run_vector(i, vecs[i]);

        // Data priority: instruction access follows the data access
        ram_auto = 1'b1; ram_lat = 0;
        ram_mem[32'h100] = 32'hDEADBEEF;
        ram_mem[32'h40]  = 32'h8C220004;
        imemREN = 1'b1; imemaddr = 32'h40;
        dmemREN = 1'b1; dmemaddr = 32'h100;
        cyc = 1;
        run_until_hit(10, kind, at, ld);
        check("prio_first_kind", 64'(kind), 64'd1);
        check("prio_first_cycle", 64'(at), 64'd3);
        check("prio_first_load", 64'(ld), 64'hDEADBEEF);
        tick();
        dmemREN = 1'b0;
        run_until_hit(10, kind, at, ld);
        check("prio_second_kind", 64'(kind), 64'd0);
        check("prio_second_cycle", 64'(at), 64'd6);
        check("prio_second_load", 64'(ld), 64'h8C220004);
        tick();
        clear_reqs();
        tick();

        // Fetch redirect during IACC: first response dropped, new fetch served
        ram_lat = 2;
        ram_mem[32'h80] = 32'h01234567;
        i0 = iacc_cnt;
        imemREN = 1'b1; imemaddr = 32'h40;
        cyc = 1;
        tick();
        imemaddr = 32'h80;
        run_until_hit(30, kind, at, ld);
        check("redir_kind", 64'(kind), 64'd0);
        check("redir_cycle", 64'(at), 64'd10);
        check("redir_load", 64'(ld), 64'h01234567);
        tick();
        clear_reqs();
        tick();
        check("redir_iacc", 64'(iacc_cnt), 64'(i0 + 32'd1));

        // Timeout: RAM stays BUSY
        ram_lat = 100000;
        dmemREN = 1'b1; dmemaddr = 32'h10;
        cyc = 1;
        for (int k = 0; k < 255; k++) tick();
        check("tmo_last_wait_memerr", 64'(memerr), 64'd0);
        check("tmo_last_wait_ramREN", 64'(ramREN), 64'd1);
        tick();
        check("tmo_err_memerr", 64'(memerr), 64'd1);
        check("tmo_err_strobes", 64'({ramREN, ramWEN}), 64'd0);
        dmemREN = 1'b0;
        imemREN = 1'b1; imemaddr = 32'h40;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            seen |= ihit | dhit | ramREN | ramWEN;
        end
        check("tmo_err_quiet", 64'(seen), 64'd0);
        check("tmo_err_sticky", 64'(memerr), 64'd1);
        do_reset();
        check("tmo_rst_memerr", 64'(memerr), 64'd0);
        check("tmo_rst_counters", {iacc_cnt, dacc_cnt}, 64'd0);
        ram_lat = 0;
        imemREN = 1'b1; imemaddr = 32'h40;
        cyc = 1;
        run_until_hit(10, kind, at, ld);
        check("tmo_recover_kind", 64'(kind), 64'd0);
        check("tmo_recover_cycle", 64'(at), 64'd3);
        tick();
        clear_reqs();
        tick();

        // RAM reports ERROR
        ram_auto = 1'b0;
        ramstate = 2'd0;
        dmemREN = 1'b1; dmemaddr = 32'h20;
        cyc = 1;
        tick();
        check("rerr_ramREN", 64'(ramREN), 64'd1);
        ramstate = 2'd3;
        dmemREN = 1'b0;
        tick();
        check("rerr_memerr", 64'(memerr), 64'd1);
        check("rerr_strobes", 64'({ramREN, ramWEN}), 64'd0);
        ramstate = 2'd2;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seen |= ihit | dhit;
        end
        check("rerr_no_hit", 64'(seen), 64'd0);
        ramstate = 2'd0;
        do_reset();
        check("rerr_rst_memerr", 64'(memerr), 64'd0);
        ram_auto = 1'b1;

        // Make a counter nonzero, then reset in the middle of a write
        ram_lat = 0;
        imemREN = 1'b1; imemaddr = 32'h40;
        cyc = 1;
        run_until_hit(10, kind, at, ld);
        tick();
        clear_reqs();
        tick();
        check("mid_pre_iacc", 64'(iacc_cnt), 64'd1);
        ram_lat = 100000;
        dmemWEN = 1'b1; dmemaddr = 32'h20; dmemstore = 32'h55;
        cyc = 1;
        tick();
        tick();
        check("mid_in_dacc", 64'(ramWEN), 64'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        dmemWEN = 1'b0;
        check("mid_rst_strobes", 64'({ramREN, ramWEN}), 64'd0);
        check("mid_rst_counters", {iacc_cnt, dacc_cnt}, 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            seen |= dhit;
        end
        check("mid_rst_no_dhit", 64'(seen), 64'd0);

        // Randomized transactions against the transaction-level model
        do_reset();
        ram_mem.delete();
        ref_mem.delete();
        ref_i = 0;
        ref_d = 0;
        for (int t = 0; t < 150; t++) begin
            int          sel, lat, len;
            bit          ir, dr, dw, h_d, h_i, pend_d, pend_i;
            logic [31:0] ia, da, st;
            ev_t         e;
            sel = $urandom_range(0, 4);
            ir  = (sel == 0) || (sel >= 3);
            dr  = (sel == 1) || (sel == 3) || ((sel == 2) && ($urandom_range(0, 1) == 1));
            dw  = (sel == 2) || (sel == 4);
            lat = $urandom_range(0, 3);
            ia  = 32'($urandom_range(0, 15)) << 2;
            da  = 32'($urandom_range(0, 15)) << 2;
            st  = $urandom;

            // Expected responses: data first, fetch after the next IDLE
            if (dr || dw) begin
                e.kind = 1;
                e.at   = 3 + lat;
                e.ld   = dw ? 32'd0 : ref_rd(da);
                if (dw) ref_mem[da] = st;
                exp_q.push_back(e);
                ref_d++;
            end
            if (ir) begin
                e.kind = 0;
                e.at   = (dr || dw) ? 2 * (3 + lat) : 3 + lat;
                e.ld   = ref_rd(ia);
                exp_q.push_back(e);
                ref_i++;
            end

            ram_lat = lat;
            imemREN = ir; imemaddr = ia;
            dmemREN = dr; dmemWEN = dw; dmemaddr = da; dmemstore = st;
            cyc = 1;
            pend_d = 1'b0;
            pend_i = 1'b0;
            len = 2 * (3 + lat) + 5;
            for (int k = 0; k < len; k++) begin
                tick();
                h_d = dhit;
                h_i = ihit;
                if (h_d) begin e.kind = 1; e.at = cyc; e.ld = dmemload; obs_q.push_back(e); end
                if (h_i) begin e.kind = 0; e.at = cyc; e.ld = imemload; obs_q.push_back(e); end
                if (pend_d) begin dmemREN = 1'b0; dmemWEN = 1'b0; end
                if (pend_i) imemREN = 1'b0;
                pend_d = h_d;
                pend_i = h_i;
            end
            clear_reqs();

            check($sformatf("rnd%0d_nresp", t), 64'(obs_q.size()), 64'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                check($sformatf("rnd%0d_r%0d_kind", t, i), 64'(obs_q[i].kind), 64'(exp_q[i].kind));
                check($sformatf("rnd%0d_r%0d_cycle", t, i), 64'(obs_q[i].at), 64'(exp_q[i].at));
                check($sformatf("rnd%0d_r%0d_load", t, i), 64'(obs_q[i].ld), 64'(exp_q[i].ld));
            end
            check($sformatf("rnd%0d_iacc", t), 64'(iacc_cnt), 64'(ref_i));
            check($sformatf("rnd%0d_dacc", t), 64'(dacc_cnt), 64'(ref_d));
            exp_q.delete();
            obs_q.delete();
        end
        check("rnd_memerr", 64'(memerr), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
